// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI receive path.
package spi_pkg;

  localparam int SPI_WIDTH = 16;

  function automatic int bit_cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int SPI_BIT_CNT_W = bit_cnt_w(SPI_WIDTH);

  typedef enum logic {IDLE, ACTIVE} spi_state_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// Synchronous FIFO with a registered head word; a push into an empty FIFO is visible on the next edge.
module spi_rx_fifo #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_next = rd_ptr + AW'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // The head register looks ahead so it always holds the entry at the post-update read pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_next;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      head <= (do_push && (wr_ptr == rd_next)) ? push_data : mem[rd_next];
    end
  end

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver oversampled in the clk domain, with response shifter and receive FIFO.
// Optional SPI_SLAVE_FRAME_CHECK_EN adds the frame_err pulse output.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int WIDTH      = SPI_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spi_cs_l,
  input  logic             spi_clk,
  input  logic             spi_data,
  output logic             master_data,
  input  logic [WIDTH-1:0] tx_word,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_overflow,
`ifdef SPI_SLAVE_FRAME_CHECK_EN
  output logic             busy,
  output logic             frame_err
`else
  output logic             busy
`endif
);

  localparam int CNT_W = bit_cnt_w(WIDTH);

  spi_state_t       state;
  logic             cs_meta, cs_sync, cs_prev;
  logic             clk_meta, clk_sync, clk_prev;
  logic             data_meta, data_sync;
  logic             cs_seen_high;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-2:0] rx_shift;
  logic [WIDTH-1:0] tx_shift;
  logic             clk_rise, clk_fall, cs_fall, cs_rise;
  logic             last_bit, word_push, rx_pop;
  logic             fifo_empty, fifo_full;

  // Chains reset low so a CS held low across reset never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      {cs_meta, cs_sync, cs_prev}    <= '0;
      {clk_meta, clk_sync, clk_prev} <= '0;
      {data_meta, data_sync}         <= '0;
      cs_seen_high                   <= 1'b0;
      busy                           <= 1'b0;
    end else begin
      {cs_meta, cs_sync, cs_prev}    <= {spi_cs_l, cs_meta, cs_sync};
      {clk_meta, clk_sync, clk_prev} <= {spi_clk, clk_meta, clk_sync};
      {data_meta, data_sync}         <= {spi_data, data_meta};
      cs_seen_high                   <= cs_seen_high | cs_sync;
      busy                           <= ~cs_meta & cs_seen_high;
    end
  end

  assign clk_rise  = clk_sync & ~clk_prev;
  assign clk_fall  = ~clk_sync & clk_prev;
  assign cs_fall   = ~cs_sync & cs_prev;
  assign cs_rise   = cs_sync & ~cs_prev;
  assign last_bit  = (bit_cnt == CNT_W'(WIDTH - 1));
  assign word_push = (state == ACTIVE) && !cs_rise && clk_rise && last_bit;
  assign rx_pop    = rx_valid && rx_ready;
  assign rx_valid  = ~fifo_empty;

  // tx_shift holds the bits still to be presented; master_data takes its MSB on each falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      master_data <= 1'b0;
      rx_overflow <= 1'b0;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
      frame_err   <= 1'b0;
`endif
    end else begin
`ifdef SPI_SLAVE_FRAME_CHECK_EN
      frame_err <= 1'b0;
`endif
      if (word_push && fifo_full && !rx_pop) rx_overflow <= 1'b1;
      case (state)
        IDLE: begin
          master_data <= 1'b0;
          bit_cnt     <= '0;
          if (cs_fall) begin
            state       <= ACTIVE;
            tx_shift    <= tx_word << 1;
            master_data <= tx_word[WIDTH-1];
`ifdef SPI_SLAVE_FRAME_CHECK_EN
            frame_err   <= clk_sync;
`endif
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            master_data <= 1'b0;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
            frame_err   <= (bit_cnt != '0);
`endif
          end else begin
            if (clk_rise) begin
              rx_shift <= {rx_shift[WIDTH-3:0], data_sync};
              if (last_bit) begin
                bit_cnt  <= '0;
                tx_shift <= tx_word;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            if (clk_fall) begin
              master_data <= tx_shift[WIDTH-1];
              tx_shift    <= tx_shift << 1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  spi_rx_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (word_push),
    .push_data ({rx_shift, data_sync}),
    .pop       (rx_pop),
    .head      (rx_data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: vector table of single frames plus hand-written multi-cycle corner cases.
module tb_spi_slave_rx;

  localparam int W    = 16;
  localparam int HALF = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         spi_cs_l;
  logic         spi_clk;
  logic         spi_data;
  logic         master_data;
  logic [W-1:0] tx_word;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic         rx_overflow;
  logic         busy;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
  logic         frame_err;
  int           fe_count = 0;
  int           fe_base;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] mosi;
    logic [W-1:0] resp;
    logic [W-1:0] exp_rx;
    logic [W-1:0] exp_miso;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  spi_slave_rx #(.WIDTH(W), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .spi_cs_l    (spi_cs_l),
    .spi_clk     (spi_clk),
    .spi_data    (spi_data),
    .master_data (master_data),
    .tx_word     (tx_word),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_overflow (rx_overflow),
`ifdef SPI_SLAVE_FRAME_CHECK_EN
    .busy        (busy),
    .frame_err   (frame_err)
`else
    .busy        (busy)
`endif
  );

`ifdef SPI_SLAVE_FRAME_CHECK_EN
  always @(posedge clk) if (!reset && frame_err) fe_count++;
`endif

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SPI bit, mode 0; optionally pulses rx_ready for the single cycle the rising edge is acted on.
  task automatic spiBit(input logic b, input logic pop_on_rise, output logic miso);
    spi_data = b;
    waitCycles(HALF);
    miso    = master_data;
    spi_clk = 1'b1;
    if (pop_on_rise) begin
      waitCycles(2);
      rx_ready = 1'b1;
      waitCycles(1);
      rx_ready = 1'b0;
      waitCycles(HALF - 3);
    end else begin
      waitCycles(HALF);
    end
    spi_clk = 1'b0;
  endtask

  task automatic spiWord(input logic [W-1:0] w, input logic pop_last, output logic [W-1:0] miso);
    logic m;
    miso = '0;
    for (int i = W - 1; i >= 0; i--) begin
      spiBit(w[i], pop_last && (i == 0), m);
      miso[i] = m;
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] mosi, input logic [W-1:0] resp,
                               input logic pop_last, output logic [W-1:0] miso);
    tx_word = resp;
    waitCycles(2);
    spi_cs_l = 1'b0;
    waitCycles(HALF);
    spiWord(mosi, pop_last, miso);
    waitCycles(4);
    spi_cs_l = 1'b1;
    waitCycles(HALF);
  endtask

  task automatic popWord();
    rx_ready = 1'b1;
    waitCycles(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] miso;
    logic [W-1:0] miso2;
    logic         m;
    logic [W-1:0] ovf_words[5];
    logic [W-1:0] full_words[4];

    vecs[0] = '{mosi: 16'hA569, resp: 16'h3425, exp_rx: 16'hA569, exp_miso: 16'h3425};
    vecs[1] = '{mosi: 16'h0000, resp: 16'hFFFF, exp_rx: 16'h0000, exp_miso: 16'hFFFF};
    vecs[2] = '{mosi: 16'hFFFF, resp: 16'h0000, exp_rx: 16'hFFFF, exp_miso: 16'h0000};
    vecs[3] = '{mosi: 16'h8001, resp: 16'h7FFE, exp_rx: 16'h8001, exp_miso: 16'h7FFE};
    vecs[4] = '{mosi: 16'h1E2D, resp: 16'hC35A, exp_rx: 16'h1E2D, exp_miso: 16'hC35A};
    ovf_words  = '{16'h11A1, 16'h22B2, 16'h33C3, 16'h44D4, 16'h55E5};
    full_words = '{16'hF00D, 16'hBEEF, 16'hCAFE, 16'h1357};

    reset    = 1'b1;
    spi_cs_l = 1'b1;
    spi_clk  = 1'b0;
    spi_data = 1'b0;
    tx_word  = '0;
    rx_ready = 1'b0;
    waitCycles(3);
    checkOutput("reset master_data", master_data, 1'b0);
    checkOutput("reset rx_valid", rx_valid, 1'b0);
    checkOutput("reset rx_overflow", rx_overflow, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset rx_data", rx_data, 16'h0000);
    reset = 1'b0;
    waitCycles(6);
    checkOutput("idle busy", busy, 1'b0);

    spi_cs_l = 1'b0;
    waitCycles(3);
    checkOutput("busy on cs low", busy, 1'b1);
    spi_cs_l = 1'b1;
    waitCycles(3);
    checkOutput("busy on cs high", busy, 1'b0);
    waitCycles(HALF);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].mosi, vecs[i].resp, 1'b0, miso);
      checkOutput($sformatf("vec%0d rx_valid", i), rx_valid, 1'b1);
      checkOutput($sformatf("vec%0d rx_data", i), rx_data, vecs[i].exp_rx);
      checkOutput($sformatf("vec%0d miso", i), miso, vecs[i].exp_miso);
      checkOutput($sformatf("vec%0d idle master_data", i), master_data, 1'b0);
      popWord();
      checkOutput($sformatf("vec%0d rx_valid after pop", i), rx_valid, 1'b0);
    end

    // Back-to-back words in one CS window; the response is reloaded at the word boundary.
    tx_word = 16'h1111;
    waitCycles(2);
    spi_cs_l = 1'b0;
    waitCycles(HALF);
    spiBit(1'b0, 1'b0, m);
    miso = '0;
    miso[W-1] = m;
    tx_word = 16'h7E0F;
    for (int i = W - 2; i >= 0; i--) begin
      spiBit(16'h2563 >> i, 1'b0, m);
      miso[i] = m;
    end
    spiWord(16'h9B63, 1'b0, miso2);
    waitCycles(4);
    spi_cs_l = 1'b1;
    waitCycles(HALF);
    checkOutput("b2b first miso", miso, 16'h1111);
    checkOutput("b2b second miso", miso2, 16'h7E0F);
    checkOutput("b2b rx_data 0", rx_data, 16'h2563);
    popWord();
    checkOutput("b2b rx_valid 1", rx_valid, 1'b1);
    checkOutput("b2b rx_data 1", rx_data, 16'h9B63);
    popWord();
    checkOutput("b2b empty", rx_valid, 1'b0);

    // Overflow: fifth word is dropped.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(ovf_words[k], 16'h0000, 1'b0, miso);
      if (k == 3) checkOutput("ovf not yet", rx_overflow, 1'b0);
    end
    checkOutput("ovf set", rx_overflow, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("ovf read %0d", k), rx_data, ovf_words[k]);
      popWord();
    end
    checkOutput("ovf drained", rx_valid, 1'b0);
    checkOutput("ovf sticky", rx_overflow, 1'b1);
    reset = 1'b1;
    waitCycles(2);
    reset = 1'b0;
    waitCycles(6);
    checkOutput("ovf cleared by reset", rx_overflow, 1'b0);

    // Partial frame: 7 bits then CS high.
`ifdef SPI_SLAVE_FRAME_CHECK_EN
    fe_base = fe_count;
`endif
    spi_cs_l = 1'b0;
    waitCycles(HALF);
    for (int i = 0; i < 7; i++) spiBit(1'(i), 1'b0, m);
    waitCycles(4);
    spi_cs_l = 1'b1;
    waitCycles(HALF);
    checkOutput("partial no push", rx_valid, 1'b0);
`ifdef SPI_SLAVE_FRAME_CHECK_EN
    checkOutput("partial frame_err pulses", W'(fe_count - fe_base), 16'd1);
`endif
    applyStimulus(16'h6A61, 16'h0F0F, 1'b0, miso);
    checkOutput("after partial rx_data", rx_data, 16'h6A61);
    checkOutput("after partial miso", miso, 16'h0F0F);
    popWord();

`ifdef SPI_SLAVE_FRAME_CHECK_EN
    // CS falling while spi_clk is high is a mode violation.
    fe_base = fe_count;
    spi_clk = 1'b1;
    waitCycles(4);
    spi_cs_l = 1'b0;
    waitCycles(6);
    spi_clk = 1'b0;
    waitCycles(6);
    spi_cs_l = 1'b1;
    waitCycles(HALF);
    checkOutput("mode violation frame_err", W'(fe_count - fe_base), 16'd1);
    checkOutput("mode violation no push", rx_valid, 1'b0);
`endif

    // Word completing into a full FIFO with a same-cycle pop is accepted.
    for (int k = 0; k < 4; k++) applyStimulus(full_words[k], 16'h0000, 1'b0, miso);
    applyStimulus(16'h0001, 16'h0000, 1'b1, miso);
    checkOutput("full+pop no overflow", rx_overflow, 1'b0);
    checkOutput("full+pop read 0", rx_data, full_words[1]);
    popWord();
    checkOutput("full+pop read 1", rx_data, full_words[2]);
    popWord();
    checkOutput("full+pop read 2", rx_data, full_words[3]);
    popWord();
    checkOutput("full+pop read 3", rx_data, 16'h0001);
    popWord();
    checkOutput("full+pop drained", rx_valid, 1'b0);

    // Reset in the middle of a frame with CS held low.
    applyStimulus(16'h5A5A, 16'h0000, 1'b0, miso);
    checkOutput("pre-reset rx_data", rx_data, 16'h5A5A);
    tx_word = 16'hFFFF;
    waitCycles(2);
    spi_cs_l = 1'b0;
    waitCycles(HALF);
    for (int i = 0; i < 9; i++) spiBit(1'b1, 1'b0, m);
    waitCycles(4);
    checkOutput("pre-reset master_data", master_data, 1'b1);
    checkOutput("pre-reset busy", busy, 1'b1);
    reset = 1'b1;
    waitCycles(2);
    checkOutput("midreset master_data", master_data, 1'b0);
    checkOutput("midreset rx_valid", rx_valid, 1'b0);
    checkOutput("midreset rx_overflow", rx_overflow, 1'b0);
    checkOutput("midreset busy", busy, 1'b0);
    checkOutput("midreset rx_data", rx_data, 16'h0000);
    reset = 1'b0;
    waitCycles(4);
    spiWord(16'h1234, 1'b0, miso);
    waitCycles(4);
    checkOutput("cs held low ignored", rx_valid, 1'b0);
    checkOutput("cs held low master_data", miso, 16'h0000);
    checkOutput("cs held low busy", busy, 1'b0);
    spi_cs_l = 1'b1;
    waitCycles(HALF);
    applyStimulus(16'h9B22, 16'h5AC3, 1'b0, miso);
    checkOutput("post-reset rx_valid", rx_valid, 1'b1);
    checkOutput("post-reset rx_data", rx_data, 16'h9B22);
    checkOutput("post-reset miso", miso, 16'h5AC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

Downstream companion to the `spi` master. The block receives the master's serial frames on `spi_cs_l`, `spi_clk` and `spi_data`, and oversamples them in the system clock domain. It assembles 16-bit MSB-first words and buffers them in a small FIFO with a valid/ready read port. During each frame it shifts a response word back to the master on `master_data`.

## Interface
Parameters:
- `WIDTH`, 16: frame/word width in bits.
- `FIFO_DEPTH`, 4: receive FIFO entries; power of two, ≥2.

Ports:
- `clk` in 1: system clock, the only clock.
- `reset` in 1: synchronous, active-high reset.
- `spi_cs_l` in 1: chip select from master, active low, asynchronous to `clk`.
- `spi_clk` in 1: serial clock from master, asynchronous; frequency ≤ `clk`/8.
- `spi_data` in 1: MOSI from master.
- `master_data` out 1: MISO to master.
- `tx_word` in WIDTH: response word; captured at frame start and at each word boundary.
- `rx_data` out WIDTH: FIFO head word.
- `rx_valid` out 1: FIFO non-empty.
- `rx_ready` in 1: consumer pops the head when `rx_valid && rx_ready`.
- `rx_overflow` out 1: sticky; set when a completed word is dropped.
- `busy` out 1: high while the synchronized CS is low.
- `frame_err` out 1: only with `SPI_SLAVE_FRAME_CHECK_EN`; 1-cycle pulse.

## Operation
- Input conditioning: `spi_cs_l`, `spi_clk` and `spi_data` each pass through a 2-FF synchronizer. A third register per line gives edge detect: `clk_rise`, `clk_fall`, `cs_fall`, `cs_rise`.
- States:
  - IDLE (CS high) → ACTIVE on `cs_fall`.
  - ACTIVE → IDLE on `cs_rise`.
  - Reset forces IDLE.
- ACTIVE receive, on `clk_rise`:
  - Shift `spi_data` (synchronized) into the shift register, MSB first.
  - Increment the bit counter (width $clog2(WIDTH)+1).
- At the 16th bit:
  - Push the assembled word to the FIFO.
  - Clear the bit counter.
  - Reload the transmit shifter from `tx_word`.
  - Further bits in the same CS window start a new word (back-to-back frames).
- Transmit:
  - On `cs_fall`, capture `tx_word` and drive `master_data` = `tx_word[15]`.
  - On each `clk_fall` in ACTIVE, shift left; `master_data` becomes the next bit.
  - `master_data` is 0 in IDLE.
- Partial frame: `cs_rise` with bit counter ≠ 0 discards the partial word, clears the counter, and pushes nothing.
- FIFO push rules:
  - A push while full is accepted only if a pop occurs in the same cycle.
  - Otherwise the word is dropped and `rx_overflow` is set; it is cleared only by reset.
  - Simultaneous push and pop when empty: the push lands and `rx_valid` rises next cycle.
- Reset values:
  - `master_data`, `rx_valid`, `rx_overflow`, `busy`, `frame_err`, `rx_data` = 0.
  - Bit counter and FIFO pointers = 0; state IDLE.
- Reset mid-frame: everything is cleared, and the slave waits for the next `cs_fall`. A CS already low at reset release is ignored until CS goes high and then low again.

## Timing
- Pin-to-event latency: 3 `clk` cycles from any SPI pin edge to its detect strobe.
- Word complete: the push happens in the cycle the 16th `clk_rise` is detected; `rx_valid`/`rx_data` are valid on the next `clk` edge.
- `rx_data` is registered from the FIFO head. A pop updates `rx_data` and `rx_valid` on the next edge.
- `master_data` changes 1 cycle after the `clk_fall` strobe. Total delay from the pin is 4 `clk` cycles, which must stay within half an `spi_clk` period; this is why `spi_clk` ≤ `clk`/8.
- `busy` follows the synchronized CS, 2 cycles after the pin.

## Configuration
- `SPI_SLAVE_FRAME_CHECK_EN` defined:
  - `frame_err` pulses for 1 cycle on `cs_rise` when the bit counter ≠ 0.
  - `frame_err` also pulses when `spi_clk` (synchronized) is high at `cs_fall`, which is a mode violation.
- Not defined: the `frame_err` port is absent, and partial frames are silently discarded.

## Structure
- `spi_pkg` holds:
  - `SPI_WIDTH` = 16.
  - The bit-counter width constant.
  - State enum `{IDLE, ACTIVE}`.
- One sub-module, `spi_rx_fifo`: a synchronous FIFO with push/pop, full/empty and count. Parameters are WIDTH and FIFO_DEPTH. It uses `clk`/`reset` and is reused by other SPI stages.
- Synchronizers and edge detect stay inline.

## Test plan
- Single frame: send 16'hA569 MSB first with `tx_word`=16'h3425 → `rx_data`=16'hA569 with `rx_valid` high; the master samples 16'h3425 on `master_data`.
- Back-to-back: 16'h2563 then 16'h9B63 in one CS window, `rx_ready` held low → two FIFO entries, popped in order; the second MISO word equals `tx_word` sampled at bit 16.
- Overflow: 5 words with `rx_ready`=0 at depth 4 → the 5th is dropped, `rx_overflow`=1, and reads return the first 4 words in order.
- Partial frame: CS low, 7 bits, CS high → no push, counter cleared. With `SPI_SLAVE_FRAME_CHECK_EN`, `frame_err` pulses once. The next full frame 16'h6A61 is received intact.
- Full FIFO with same-cycle pop: 16'h0001 completes while full and `rx_ready`=1 → the push is accepted and `rx_overflow` stays 0.
- Reset mid-frame after 9 bits → all outputs 0. With CS held low, nothing is received until CS toggles high then low; the following 16'h9B22 frame is received correctly.
